// File: rtl/ctech_lib_prbs_chk.sv
// Serial PRBS checker. Self-seeds from the received stream, verifies
// LOCK_CNT consecutive predicted bits, then flywheels on its own
// prediction while counting errors. Too many errors in one window drops
// lock and restarts seeding.
module ctech_lib_prbs_chk #(
  parameter int PRBS        = 7,
  parameter int LOCK_CNT    = 16,
  parameter int WIN         = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_vld,
  input  logic             din,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_now,
  output logic [CNT_W-1:0] err_cnt,
  output logic             sat
);

  // Second feedback tap for each supported polynomial order.
  localparam int TAP = (PRBS == 7)  ? 6  :
                       (PRBS == 15) ? 14 :
                       (PRBS == 23) ? 18 : 28;
  localparam int WW  = $clog2(WIN + 1);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [PRBS-1:0]   sr_q, sr_d;
  logic [4:0]        fill_q, fill_d, fill_inc;
  logic [7:0]        match_q, match_d, match_inc;
  logic [WW-1:0]     win_cnt_q, win_cnt_d, win_cnt_inc;
  logic [WW-1:0]     win_err_q, win_err_d, win_err_inc;
  logic              locked_d, err_now_d, sat_d;
  logic [CNT_W-1:0]  err_cnt_d;
  logic              pred, mis, err_hit;

  // Next-state, datapath and output decode; nothing moves without din_vld.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q_w();
    sat_d       = sat;
    err_hit     = 1'b0;
    pred        = sr_q[PRBS-1] ^ sr_q[TAP-1];
    mis         = din ^ pred;
    fill_inc    = fill_q + 5'd1;
    match_inc   = match_q + 8'd1;
    win_cnt_inc = win_cnt_q + WW'(1);
    win_err_inc = win_err_q + WW'(mis);

    if (din_vld) begin
      case (state_q)
        SEED: begin
          sr_d   = {sr_q[PRBS-2:0], din};
          fill_d = fill_inc;
          if (fill_inc == 5'(PRBS)) begin
            state_d = VERIFY;
            match_d = '0;
          end
        end
        VERIFY: begin
          sr_d = {sr_q[PRBS-2:0], din};
          if (!mis) begin
            match_d = match_inc;
            if (match_inc == 8'(LOCK_CNT)) begin
              state_d   = LOCKED;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            state_d = SEED;
            fill_d  = '0;
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: keep running on the prediction so a corrupted bit
          // never enters the register.
          sr_d    = {sr_q[PRBS-2:0], pred};
          err_hit = mis;
          if (win_err_inc == WW'(LOSS_THRESH)) begin
            state_d   = SEED;
            fill_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_inc == WW'(WIN)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_inc;
            win_err_d = win_err_inc;
          end
        end
        default: state_d = SEED;
      endcase
    end

    // Clear takes precedence, but an error in the same cycle still counts.
    if (clr_err) begin
      err_cnt_d = {{(CNT_W-1){1'b0}}, err_hit};
      sat_d     = 1'b0;
    end else if (err_hit && !(&err_cnt)) begin
      err_cnt_d = err_cnt + CNT_W'(1);
      sat_d     = sat | (&err_cnt_d);
    end

    err_now_d = err_hit;
    locked_d  = (state_d == LOCKED);
  end

  function automatic logic [CNT_W-1:0] err_cnt_q_w();
    return err_cnt;
  endfunction

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEED;
      sr_q      <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      locked    <= 1'b0;
      err_now   <= 1'b0;
      err_cnt   <= '0;
      sat       <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      locked    <= locked_d;
      err_now   <= err_now_d;
      err_cnt   <= err_cnt_d;
      sat       <= sat_d;
    end
  end

endmodule

// File: tb/tb_ctech_lib_prbs_chk.sv
// Bench for ctech_lib_prbs_chk: directed scenario steps driving an ideal
// PRBS7 stream with injected bit flips, checked every cycle against a
// behavioural model plus scenario-specific expectations.
module tb_ctech_lib_prbs_chk;
  localparam int PRBS = 7, TAP = 6, LOCK_CNT = 16, WIN = 64, THR = 8, CNT_W = 4;
  localparam int MAXC = (1 << CNT_W) - 1;
  localparam int NSEQ = 150;

  logic clk = 1'b0, rst = 1'b1, din_vld = 1'b0, din = 1'b0, clr_err = 1'b0;
  logic locked, err_now, sat;
  logic [CNT_W-1:0] err_cnt;

  ctech_lib_prbs_chk #(.PRBS(PRBS), .LOCK_CNT(LOCK_CNT), .WIN(WIN),
                       .LOSS_THRESH(THR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .clr_err(clr_err),
    .locked(locked), .err_now(err_now), .err_cnt(err_cnt), .sat(sat));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit stream [0:3999];
  int k;

  // Reference model state
  int   m_st, m_fill, m_match, m_wc, m_we, m_cnt;
  bit   m_locked, m_err_now, m_sat;
  bit   hist [$];

  bit        flipmask [0:NSEQ-1];
  logic [6:0] rec [0:NSEQ-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit d, input bit c);
    bit p, err;
    err = 1'b0;
    if (r) begin
      m_st = 0; m_fill = 0; m_match = 0; m_wc = 0; m_we = 0; m_cnt = 0;
      m_locked = 0; m_err_now = 0; m_sat = 0;
      hist.delete();
      repeat (PRBS) hist.push_back(1'b0);
      return;
    end
    if (v) begin
      // hist[0] is the bit PRBS positions back, hist[PRBS-TAP] is TAP back
      p = hist[0] ^ hist[PRBS-TAP];
      void'(hist.pop_front());
      if (m_st == 0) begin
        hist.push_back(d);
        m_fill++;
        if (m_fill == PRBS) begin m_st = 1; m_match = 0; end
      end else if (m_st == 1) begin
        hist.push_back(d);
        if (d == p) begin
          m_match++;
          if (m_match == LOCK_CNT) begin m_st = 2; m_wc = 0; m_we = 0; end
        end else begin
          m_st = 0; m_fill = 0; m_match = 0;
        end
      end else begin
        hist.push_back(p);
        err = (d != p);
        m_wc++;
        if (err) m_we++;
        if (m_we == THR) begin m_st = 0; m_fill = 0; m_wc = 0; m_we = 0; end
        else if (m_wc == WIN) begin m_wc = 0; m_we = 0; end
      end
    end
    m_err_now = err;
    if (c) begin
      m_cnt = err ? 1 : 0;
      m_sat = 0;
    end else if (err && m_cnt != MAXC) begin
      m_cnt++;
      if (m_cnt == MAXC) m_sat = 1;
    end
    m_locked = (m_st == 2);
  endtask

  task automatic cyc(input bit r, input bit v, input bit d, input bit c);
    rst = r; din_vld = v; din = d; clr_err = c;
    @(posedge clk); #1;
    model_step(r, v, d, c);
    chk("m_locked",  locked,  m_locked);
    chk("m_err_now", err_now, m_err_now);
    chk("m_err_cnt", err_cnt, m_cnt);
    chk("m_sat",     sat,     m_sat);
  endtask

  task automatic send(input bit flip);
    cyc(1'b0, 1'b1, stream[k] ^ flip, 1'b0);
    k++;
  endtask

  task automatic send_clr(input bit flip);
    cyc(1'b0, 1'b1, stream[k] ^ flip, 1'b1);
    k++;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // One fixed flip pattern, optionally with random idle cycles between bits.
  task automatic run_seq(input bit gaps);
    do_reset();
    k = 0;
    for (int i = 0; i < NSEQ; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 1'($urandom), 1'b0);
      send(flipmask[i]);
      if (!gaps) rec[i] = {locked, err_now, err_cnt, sat};
      else chk("gap_equiv", {25'd0, locked, err_now, err_cnt, sat}, {25'd0, rec[i]});
    end
  endtask

  initial begin
    for (int i = 0; i < 4000; i++)
      stream[i] = (i < PRBS) ? 1'b1 : (stream[i-PRBS] ^ stream[i-TAP]);

    // Clean lock from reset
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_err_cnt", err_cnt, 0);
    k = 0;
    for (int i = 1; i <= 23; i++) begin
      send(1'b0);
      if (i < 23) chk("lock_early", locked, 0);
      else        chk("lock_at23", locked, 1);
    end
    chk("lock_err_cnt", err_cnt, 0);

    // Single error while locked; flywheel must not propagate it
    send_clr(1'b0);
    send(1'b1);
    chk("single_err_now", err_now, 1);
    chk("single_err_cnt", err_cnt, 1);
    chk("single_locked", locked, 1);
    send(1'b0);
    chk("single_pulse_end", err_now, 0);
    repeat (30) send(1'b0);
    chk("single_no_prop", err_cnt, 1);

    // Mismatch on bit 12 while verifying
    do_reset();
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      send(i == 12);
      if (i == 34) chk("verify_nolock34", locked, 0);
      if (i == 35) chk("verify_lock35", locked, 1);
    end
    chk("verify_err_cnt", err_cnt, 0);

    // Eight errors inside one window force loss of lock, then relock
    send_clr(1'b0);
    for (int j = 1; j <= 24; j++) begin
      send(j % 3 == 0);
      if (j == 21) chk("loss_still_locked", locked, 1);
    end
    chk("loss_locked", locked, 0);
    chk("loss_err_now", err_now, 1);
    chk("loss_err_cnt", err_cnt, 8);
    for (int i = 1; i <= 23; i++) begin
      send(1'b0);
      if (i == 22) chk("relock_early", locked, 0);
    end
    chk("relock", locked, 1);
    chk("relock_err_kept", err_cnt, 8);

    // Saturation: 20 errors spaced so no window reaches the threshold
    send_clr(1'b0);
    for (int e = 0; e < 20; e++) begin
      repeat ($urandom_range(9, 15)) send(1'b0);
      send(1'b1);
    end
    chk("sat_err_cnt", err_cnt, MAXC);
    chk("sat_flag", sat, 1);
    chk("sat_locked", locked, 1);
    send_clr(1'b1);
    chk("clr_coll_cnt", err_cnt, 1);
    chk("clr_coll_sat", sat, 0);
    chk("clr_coll_now", err_now, 1);
    repeat (5) send(1'b0);

    // Gap-free run versus the same bits with random valid gaps
    for (int i = 0; i < NSEQ; i++)
      flipmask[i] = (i >= 30) && ($urandom_range(0, 19) == 0);
    run_seq(1'b0);
    run_seq(1'b1);

    // Reset while locked
    do_reset();
    k = 0;
    repeat (23) send(1'b0);
    chk("prerst_locked", locked, 1);
    send(1'b1);
    chk("prerst_err", err_cnt, 1);
    cyc(1'b1, 1'b1, stream[k], 1'b0);
    chk("rst_mid_locked", locked, 0);
    chk("rst_mid_err_now", err_now, 0);
    chk("rst_mid_err_cnt", err_cnt, 0);
    chk("rst_mid_sat", sat, 0);
    for (int i = 1; i <= 23; i++) begin
      send(1'b0);
      if (i == 22) chk("rst_relock_early", locked, 0);
    end
    chk("rst_relock23", locked, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
